// File: rtl/vecmac_accum.sv
// vecmac_accum: reduces the four unsigned 16-bit lane products of each beat
// to one sum and accumulates a programmed number of beats into a saturating
// dot-product result, handed downstream through a valid/ready handshake.
module vecmac_accum #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [63:0]      in_product,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_ZERO = '0;

    state_t           state_q,   state_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic             ovf_q,     ovf_d;
    logic [LEN_W-1:0] cnt_q,     cnt_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic             out_ovf_q, out_ovf_d;

    logic [17:0]      beat_sum_s;
    logic [ACC_W:0]   acc_sum_s;
    logic [ACC_W-1:0] acc_sat_s;
    logic             ovf_new_s;
    logic             job_start_s;

    // Lane reduction, widened add with carry-out, and saturation of the running sum.
    always_comb begin
        beat_sum_s = {2'b00, in_product[15:0]}  + {2'b00, in_product[31:16]}
                   + {2'b00, in_product[47:32]} + {2'b00, in_product[63:48]};
        acc_sum_s  = {1'b0, acc_q} + {{(ACC_W-17){1'b0}}, beat_sum_s};
        if (acc_sum_s[ACC_W]) begin
            acc_sat_s = '1;
        end else begin
            acc_sat_s = acc_sum_s[ACC_W-1:0];
        end
        ovf_new_s   = ovf_q | acc_sum_s[ACC_W];
        // A new job may begin from IDLE or on the DONE handshake cycle (back-to-back).
        job_start_s = start && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && out_ready));
    end

    // Next-state logic for the job FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        out_acc_d = out_acc_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = acc_sat_s;
                    ovf_d = ovf_new_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d   = S_DONE;
                        out_acc_d = acc_sat_s;
                        out_ovf_d = ovf_new_s;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Accepted start overrides the above: latch length, clear accumulator.
        if (job_start_s) begin
            cnt_d = cfg_len;
            acc_d = '0;
            ovf_d = 1'b0;
            if (cfg_len != CNT_ZERO) begin
                state_d = S_ACC;
            end else begin
                state_d   = S_DONE;
                out_acc_d = '0;
                out_ovf_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State and datapath registers; async reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_acc_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            out_acc_q <= out_acc_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vecmac_accum.sv
// Directed self-checking bench for vecmac_accum: a 32-bit and a 20-bit
// accumulator instance share one stimulus stream.
module tb_vecmac_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [63:0] in_product;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_ovf,  busy;
    logic [31:0] out_acc;
    logic        in_ready2, out_valid2, out_ovf2, busy2;
    logic [19:0] out_acc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vecmac_accum #(.ACC_W(32), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_product(in_product), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_ovf(out_ovf), .busy(busy)
    );

    vecmac_accum #(.ACC_W(20), .LEN_W(8)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_product(in_product), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_acc(out_acc2),
        .out_ovf(out_ovf2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start at a falling edge; returns at the falling edge after it is taken.
    task automatic do_start(input logic [7:0] len);
        start   = 1'b1;
        cfg_len = len;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] p);
        in_valid   = 1'b1;
        in_product = p;
        @(negedge clk);
        in_valid   = 1'b0;
        in_product = 64'h0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        cfg_len    = 8'd0;
        in_valid   = 1'b0;
        in_product = 64'h0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_out_acc",   {32'd0, out_acc},   64'd0);
        chk("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Job 1: three full-scale beats.
        do_start(8'd3);
        chk("j1_in_ready", {63'd0, in_ready}, 64'd1);
        chk("j1_busy",     {63'd0, busy},     64'd1);
        send_beat(64'hFE01FE01FE01FE01);
        send_beat(64'hFE01FE01FE01FE01);
        chk("j1_not_done_early", {63'd0, out_valid}, 64'd0);
        send_beat(64'hFE01FE01FE01FE01);
        chk("j1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("j1_out_acc",   {32'd0, out_acc},   64'h000BE80C);
        chk("j1_out_ovf",   {63'd0, out_ovf},   64'd0);
        handshake();
        chk("j1_idle_valid", {63'd0, out_valid}, 64'd0);

        // Job 2: single beat with distinct lanes.
        do_start(8'd1);
        send_beat(64'h097E148416820F78);
        chk("j2_out_acc", {32'd0, out_acc}, 64'h000043FC);
        handshake();

        // Job 3: gaps between beats, stalled consumer, ignored beats and start.
        do_start(8'd2);
        send_beat(64'h1000080004000004);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        chk("j3_gap_in_ready",  {63'd0, in_ready},  64'd1);
        chk("j3_gap_out_valid", {63'd0, out_valid}, 64'd0);
        send_beat(64'h0000000060000C04);
        chk("j3_out_valid", {63'd0, out_valid}, 64'd1);
        chk("j3_in_ready",  {63'd0, in_ready},  64'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_product = 64'hFFFFFFFFFFFFFFFF;
            start      = 1'b1;
            cfg_len    = 8'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("j3_held_valid", {63'd0, out_valid}, 64'd1);
        chk("j3_held_acc",   {32'd0, out_acc},   64'h00008808);
        chk("j3_stall_ready", {63'd0, in_ready}, 64'd0);
        handshake();
        chk("j3_idle_valid",  {63'd0, out_valid}, 64'd0);
        chk("j3_idle_busy",   {63'd0, busy},      64'd0);
        chk("j3_retained_acc", {32'd0, out_acc},  64'h00008808);

        // Job 4: five full-scale beats saturate the 20-bit instance only.
        do_start(8'd5);
        for (int i = 0; i < 5; i++) begin
            send_beat(64'hFE01FE01FE01FE01);
        end
        chk("j4_acc20", {44'd0, out_acc2}, 64'h000FFFFF);
        chk("j4_ovf20", {63'd0, out_ovf2}, 64'd1);
        chk("j4_acc32", {32'd0, out_acc},  64'h0013D814);
        chk("j4_ovf32", {63'd0, out_ovf},  64'd0);
        handshake();
        do_start(8'd1);
        send_beat(64'h0);
        chk("j4b_acc20", {44'd0, out_acc2}, 64'd0);
        chk("j4b_ovf20", {63'd0, out_ovf2}, 64'd0);
        handshake();

        // Job 5: zero-length job, then back-to-back start on the handshake.
        do_start(8'd0);
        chk("j5_zero_valid", {63'd0, out_valid}, 64'd1);
        chk("j5_zero_acc",   {32'd0, out_acc},   64'd0);
        chk("j5_zero_ready", {63'd0, in_ready},  64'd0);
        start     = 1'b1;
        cfg_len   = 8'd1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        chk("j5_b2b_in_ready",  {63'd0, in_ready},  64'd1);
        chk("j5_b2b_out_valid", {63'd0, out_valid}, 64'd0);
        send_beat(64'h0000000000000001);
        chk("j5_b2b_acc", {32'd0, out_acc}, 64'd1);
        handshake();

        // Job 6: reset mid-job aborts immediately.
        do_start(8'd4);
        send_beat(64'h0001000100010001);
        send_beat(64'h0001000100010001);
        rst_n = 1'b0;
        #1;
        chk("j6_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("j6_rst_ready", {63'd0, in_ready},  64'd0);
        chk("j6_rst_busy",  {63'd0, busy},      64'd0);
        chk("j6_rst_acc",   {32'd0, out_acc},   64'd0);
        chk("j6_rst_ovf",   {63'd0, out_ovf},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("j6_idle_busy", {63'd0, busy}, 64'd0);
        do_start(8'd1);
        send_beat(64'h0001000100010001);
        chk("j6_new_valid", {63'd0, out_valid}, 64'd1);
        chk("j6_new_acc",   {32'd0, out_acc},   64'd4);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vecmac_accum.md
Name: vecmac_accum

Overview:
- Downstream consumer of the 4-lane int8 multiplier: accepts the 64-bit packed product word (four unsigned 16-bit lane products per beat).
- Reduces the four lanes to one sum per beat and accumulates over a programmed number of beats, producing one dot-product result per job.
- Sits between the multiplier and the result writeback/readout logic of the int8 vector MAC.
- Handshake-based output, so results are held until the consumer takes them.

Parameters:
- ACC_W, 32, accumulator/result width in bits (min 18).
- LEN_W, 8, width of the beat-count configuration.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a job.
- cfg_len  input  LEN_W  number of product beats in the job; sampled on the accepted start.
- in_valid  input  1  in_product is valid this cycle.
- in_product  input  64  four lane products: lane k = in_product[16k+15:16k], unsigned.
- in_ready  output  1  block accepts a beat this cycle.
- out_valid  output  1  result available.
- out_ready  input  1  downstream takes the result.
- out_acc  output  ACC_W  accumulated result.
- out_ovf  output  1  accumulator saturated during this job.
- busy  output  1  high in ACC or DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE, accumulator 0, counter 0, out_valid 0, out_acc 0, out_ovf 0, in_ready 0, busy 0.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready 0.
  - When start=1, latch cfg_len and clear the accumulator and ovf.
  - cfg_len != 0: go to ACC.
  - cfg_len == 0: go to DONE with out_acc 0.
- ACC:
  - in_ready 1; a beat is accepted when in_valid=1.
  - Beat sum = lane0+lane1+lane2+lane3, computed 18 bits wide (max 4*65025 = 260100).
  - acc_next = acc + zero-extended sum.
  - If acc_next exceeds 2^ACC_W-1, saturate to all-ones and set ovf (sticky for the job).
  - Counter decrements per accepted beat.
  - On the accepted beat that brings the counter to 0, go to DONE.
  - Cycles with in_valid=0 do not change state.
- DONE:
  - out_valid 1; out_acc and out_ovf are registered and stable until the handshake.
  - Latency: out_valid rises on the clock edge after the final accepted beat, i.e. 1 cycle.
  - out_valid && out_ready: go to IDLE, out_valid drops next cycle.
  - If start=1 on that same handshake cycle, begin a new job directly (ACC, or DONE if cfg_len=0) with cleared accumulator (back-to-back).
- Ignored inputs:
  - start in ACC, or in DONE without out_ready, is ignored.
  - in_valid while in_ready=0 is ignored; the beat is not accumulated.
- out_acc/out_ovf retain their last value after the handshake until the next DONE.
- busy = (state != IDLE).
- Reset asserted mid-job aborts immediately to reset values; no partial result is emitted.

Test Plan:
- Reset then start, cfg_len=3, three beats of 0xFE01FE01FE01FE01 -> out_valid 1 cycle after beat 3, out_acc=0x000BE80C, out_ovf=0.
- cfg_len=1, one beat 0x097E148416820F78 -> out_acc=0x000043FC (2430+5252+5762+3960=17404).
- cfg_len=2, beats separated by 4 idle in_valid=0 cycles, with out_ready held 0 for 5 cycles in DONE -> out_acc=0x00008808 held stable, in_ready=0 during DONE, extra in_valid beats not accumulated; handshake returns to IDLE.
- ACC_W=20, cfg_len=5, beats 0xFE01FE01FE01FE01 -> out_acc=0xFFFFF, out_ovf=1. Next job cfg_len=1, beat 0 -> out_acc=0, out_ovf=0.
- cfg_len=0 -> DONE on the next cycle with out_acc=0, no beats accepted. Handshake with simultaneous start, cfg_len=1, beat 0x0000000000000001 -> out_acc=1.
- Assert rst_n=0 mid-job after 2 of 4 beats -> all outputs 0 immediately. After release, IDLE; a new job of 1 beat 0x0001000100010001 gives out_acc=4.
